// File: rtl/core_arbiter_pkg.sv
// Shared constants and helpers for the core-to-device bus arbiter.
package core_arbiter_pkg;

  localparam int BUS_W = 16;

  // Round-robin successor. The wrap is explicit so that core counts which are
  // not a power of two never produce an out-of-range pointer.
  function automatic int rr_next(input int idx, input int n);
    return (idx >= n - 1) ? 0 : idx + 1;
  endfunction

endpackage

// File: rtl/core_arbiter_if.sv
// Core-side request bus and device-side bus seen by the arbiter.
interface core_arbiter_if #(
  parameter int NUM_CORES = 4
);
  import core_arbiter_pkg::*;

  logic [NUM_CORES-1:0]       core_request;
  logic [NUM_CORES-1:0]       core_wren;
  logic [NUM_CORES-1:0]       core_rden;
  logic [BUS_W*NUM_CORES-1:0] core_addr;
  logic [BUS_W*NUM_CORES-1:0] core_write_val;
  logic [NUM_CORES-1:0]       core_enable;
  logic [BUS_W-1:0]           core_read_val;
  logic [BUS_W-1:0]           device_addr;
  logic                       device_wren;
  logic                       device_rden;
  logic [BUS_W-1:0]           device_write_val;
  logic [BUS_W-1:0]           device_read_val;
  logic                       device_busy;

  modport slave (
    input  core_request, core_wren, core_rden, core_addr, core_write_val,
           device_read_val, device_busy,
    output core_enable, core_read_val, device_addr, device_wren, device_rden,
           device_write_val
  );

  modport master (
    output core_request, core_wren, core_rden, core_addr, core_write_val,
           device_read_val, device_busy,
    input  core_enable, core_read_val, device_addr, device_wren, device_rden,
           device_write_val
  );

endinterface

// File: rtl/core_arbiter_picker.sv
// rr_priority_picker: first set request at or above base, wrapping to 0.
// Purely combinational so other arbiters can reuse it.
module rr_priority_picker #(
  parameter int NUM_CORES = 4,
  parameter int ID_W      = $clog2(NUM_CORES)
) (
  input  logic [NUM_CORES-1:0] req,
  input  logic [ID_W-1:0]      base,
  output logic [NUM_CORES-1:0] grant,
  output logic [ID_W-1:0]      idx,
  output logic                 req_any
);

  logic [ID_W:0]   sum;
  logic [ID_W-1:0] cand;

  always_comb begin
    grant   = '0;
    idx     = '0;
    req_any = 1'b0;
    sum     = '0;
    cand    = '0;
    for (int off = 0; off < NUM_CORES; off++) begin
      sum = {1'b0, base} + (ID_W+1)'(off);
      if (sum >= (ID_W+1)'(NUM_CORES)) sum = sum - (ID_W+1)'(NUM_CORES);
      cand = sum[ID_W-1:0];
      if (!req_any && req[cand]) begin
        req_any     = 1'b1;
        grant[cand] = 1'b1;
        idx         = cand;
      end
    end
  end

endmodule

// File: rtl/core_arbiter.sv
// Round-robin arbiter between per-core memory ports and the shared device bus.
// Grants are same-cycle; only the pointer and last-grant record are stored.
module core_arbiter #(
  parameter int NUM_CORES     = 4,
  parameter int CORE_ID_WIDTH = $clog2(NUM_CORES)
) (
  input  logic                     clk,
  input  logic                     reset,
  core_arbiter_if.slave            bus,
  output logic                     grant_valid_l,
  output logic [CORE_ID_WIDTH-1:0] grant_id_l
);
  import core_arbiter_pkg::*;

  logic [CORE_ID_WIDTH-1:0] rr_ptr_q, rr_ptr_d;
  logic                     grant_valid_q, grant_valid_d;
  logic [CORE_ID_WIDTH-1:0] grant_id_q, grant_id_d;
  logic [NUM_CORES-1:0]     pick_onehot, grant_onehot;
  logic [CORE_ID_WIDTH-1:0] pick_idx;
  logic                     pick_any, grant_ok;

  rr_priority_picker #(
    .NUM_CORES(NUM_CORES),
    .ID_W     (CORE_ID_WIDTH)
  ) u_picker (
    .req    (bus.core_request),
    .base   (rr_ptr_q),
    .grant  (pick_onehot),
    .idx    (pick_idx),
    .req_any(pick_any)
  );

  always_comb begin
    grant_ok      = pick_any && !bus.device_busy && !reset;
    grant_onehot  = grant_ok ? pick_onehot : '0;
    rr_ptr_d      = grant_ok ? CORE_ID_WIDTH'(rr_next(int'(pick_idx), NUM_CORES)) : rr_ptr_q;
    grant_valid_d = grant_ok;
    grant_id_d    = grant_ok ? pick_idx : grant_id_q;
  end

  // AND-OR muxes keyed by the one-hot grant keep the data path one level deep.
  always_comb begin
    bus.device_addr      = '0;
    bus.device_write_val = '0;
    bus.device_wren      = 1'b0;
    bus.device_rden      = 1'b0;
    for (int i = 0; i < NUM_CORES; i++) begin
      bus.device_addr      |= {BUS_W{grant_onehot[i]}} & bus.core_addr[BUS_W*i +: BUS_W];
      bus.device_write_val |= {BUS_W{grant_onehot[i]}} & bus.core_write_val[BUS_W*i +: BUS_W];
      bus.device_wren      |= grant_onehot[i] & bus.core_wren[i];
      bus.device_rden      |= grant_onehot[i] & bus.core_rden[i];
    end
  end

  assign bus.core_enable   = grant_onehot;
  assign bus.core_read_val = bus.device_read_val;
  assign grant_valid_l     = grant_valid_q;
  assign grant_id_l        = grant_id_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      rr_ptr_q      <= '0;
      grant_valid_q <= 1'b0;
      grant_id_q    <= '0;
    end else begin
      rr_ptr_q      <= rr_ptr_d;
      grant_valid_q <= grant_valid_d;
      grant_id_q    <= grant_id_d;
    end
  end

endmodule

// File: tb/tb_core_arbiter.sv
// Scoreboard bench for core_arbiter: a 4-core and a 3-core instance driven by
// directed vectors, with a negedge monitor comparing against queued expectations.
module tb_core_arbiter;

  typedef struct {
    string tag;
    int    en;
    int    addr;
    int    wren;
    int    rden;
    int    wval;
    int    rdval;
    int    gv;
    int    gid;
    int    ptr;
  } exp_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst4, rst3;
  logic       gv4, gv3;
  logic [1:0] gid4, gid3;

  core_arbiter_if #(.NUM_CORES(4)) bus4 ();
  core_arbiter_if #(.NUM_CORES(3)) bus3 ();

  core_arbiter #(.NUM_CORES(4)) dut4 (
    .clk(clk), .reset(rst4), .bus(bus4), .grant_valid_l(gv4), .grant_id_l(gid4)
  );
  core_arbiter #(.NUM_CORES(3)) dut3 (
    .clk(clk), .reset(rst3), .bus(bus3), .grant_valid_l(gv3), .grant_id_l(gid3)
  );

  bit s_req [2][4];
  bit s_wr  [2][4];
  bit s_rd  [2][4];
  int s_addr[2][4];
  int s_wd  [2][4];
  int s_rdv [2];
  bit s_busy[2];
  bit s_rst [2];

  exp_t q4[$];
  exp_t q3[$];
  int   n_total = 0;
  int   n_pass  = 0;

  task automatic apply();
    logic [3:0]  r, w, rd;
    logic [63:0] a, wd;
    for (int d = 0; d < 2; d++) begin
      r = '0; w = '0; rd = '0; a = '0; wd = '0;
      for (int i = 0; i < 4; i++) begin
        r  |= 4'(s_req[d][i]) << i;
        w  |= 4'(s_wr[d][i]) << i;
        rd |= 4'(s_rd[d][i]) << i;
        a  |= 64'(s_addr[d][i] & 'hFFFF) << (16 * i);
        wd |= 64'(s_wd[d][i] & 'hFFFF) << (16 * i);
      end
      if (d == 0) begin
        bus4.core_request = r;  bus4.core_wren = w;  bus4.core_rden = rd;
        bus4.core_addr = a;     bus4.core_write_val = wd;
        bus4.device_read_val = 16'(s_rdv[0]);
        bus4.device_busy = s_busy[0];
        rst4 = s_rst[0];
      end else begin
        bus3.core_request = r[2:0];  bus3.core_wren = w[2:0];  bus3.core_rden = rd[2:0];
        bus3.core_addr = a[47:0];    bus3.core_write_val = wd[47:0];
        bus3.device_read_val = 16'(s_rdv[1]);
        bus3.device_busy = s_busy[1];
        rst3 = s_rst[1];
      end
    end
  endtask

  task automatic clear(input int d);
    for (int i = 0; i < 4; i++) begin
      s_req[d][i] = 1'b0; s_wr[d][i] = 1'b0; s_rd[d][i] = 1'b0;
      s_addr[d][i] = 0;   s_wd[d][i] = 0;
    end
  endtask

  task automatic req(input int d, input int i, input bit w, input bit r, input int a, input int wd);
    s_req[d][i] = 1'b1; s_wr[d][i] = w; s_rd[d][i] = r;
    s_addr[d][i] = a;   s_wd[d][i] = wd;
  endtask

  // Expected state values (ptr/gv/gid) are those held during the cycle pushed.
  task automatic push(input int d, input string tag, input int win,
                      input int ptr, input int gv, input int gid);
    exp_t e;
    e.tag   = tag;
    e.en    = (win < 0) ? 0 : (1 << win);
    e.addr  = (win < 0) ? 0 : s_addr[d][win];
    e.wren  = (win < 0) ? 0 : int'(s_wr[d][win]);
    e.rden  = (win < 0) ? 0 : int'(s_rd[d][win]);
    e.wval  = (win < 0) ? 0 : s_wd[d][win];
    e.rdval = s_rdv[d];
    e.gv    = gv;
    e.gid   = gid;
    e.ptr   = ptr;
    if (d == 0) q4.push_back(e);
    else        q3.push_back(e);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    apply();
  endtask

  task automatic chk(input string tag, input string fld, input int act, input int exp);
    n_total++;
    if (act == exp) n_pass++;
    else $display("FAIL %s.%s: got %0h want %0h", tag, fld, act, exp);
  endtask

  task automatic cmp(input exp_t e, input int en, input int addr, input int wren,
                     input int rden, input int wval, input int rdval,
                     input int gv, input int gid, input int ptr);
    chk(e.tag, "core_enable", en, e.en);
    chk(e.tag, "device_addr", addr, e.addr);
    chk(e.tag, "device_wren", wren, e.wren);
    chk(e.tag, "device_rden", rden, e.rden);
    chk(e.tag, "device_write_val", wval, e.wval);
    chk(e.tag, "core_read_val", rdval, e.rdval);
    chk(e.tag, "grant_valid_l", gv, e.gv);
    chk(e.tag, "grant_id_l", gid, e.gid);
    chk(e.tag, "rr_ptr", ptr, e.ptr);
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (q4.size() > 0) begin
      e = q4.pop_front();
      cmp(e, int'(bus4.core_enable), int'(bus4.device_addr), int'(bus4.device_wren),
          int'(bus4.device_rden), int'(bus4.device_write_val), int'(bus4.core_read_val),
          int'(gv4), int'(gid4), int'(dut4.rr_ptr_q));
    end
    if (q3.size() > 0) begin
      e = q3.pop_front();
      cmp(e, int'(bus3.core_enable), int'(bus3.device_addr), int'(bus3.device_wren),
          int'(bus3.device_rden), int'(bus3.device_write_val), int'(bus3.core_read_val),
          int'(gv3), int'(gid3), int'(dut3.rr_ptr_q));
    end
  end

  initial begin
    clear(0); clear(1);
    s_rdv[0] = 0; s_rdv[1] = 0; s_busy[0] = 0; s_busy[1] = 0;
    s_rst[0] = 1; s_rst[1] = 1;
    for (int i = 0; i < 4; i++) req(0, i, 1'b1, 1'b0, 'h2000 + i, 'h5000 + i);
    apply();

    // reset gates every grant even with all cores requesting
    tick(); push(0, "rst_gate", -1, 0, 0, 0); push(1, "rst3", -1, 0, 0, 0);

    s_rst[0] = 0; s_rst[1] = 0;
    clear(0); req(0, 2, 1'b1, 1'b0, 'h4010, 'hBEEF);
    req(1, 1, 1'b0, 1'b1, 'h0222, 0);
    tick(); push(0, "single", 2, 0, 0, 0); push(1, "w3_pre", 1, 0, 0, 0);

    clear(0); clear(1);
    tick(); push(0, "single_after", -1, 3, 1, 2); push(1, "w3_idle", -1, 2, 1, 1);

    // three-core wrap: pointer at 2, cores 0 and 1 requesting
    req(1, 0, 1'b1, 1'b0, 'h0100, 'h1111); req(1, 1, 1'b0, 1'b1, 'h0101, 0);
    tick(); push(0, "idle4", -1, 3, 0, 2); push(1, "wrap3", 0, 2, 0, 1);

    clear(1);
    tick(); push(1, "wrap3_after", -1, 1, 1, 0);

    // all four cores from reset; core 3 drives both strobes
    s_rst[0] = 1;
    for (int i = 0; i < 4; i++) req(0, i, (i != 1), (i == 1 || i == 3), 'h1000 + i, 'hA000 + i);
    tick(); push(0, "rr_rst", -1, 3, 0, 2);
    s_rst[0] = 0;
    for (int k = 0; k < 8; k++) begin
      tick();
      push(0, $sformatf("rr%0d", k), k % 4, k % 4, (k == 0) ? 0 : 1, (k == 0) ? 0 : (k - 1) % 4);
    end
    clear(0);
    tick(); push(0, "rr_end", -1, 0, 1, 3);

    // read round trip
    req(0, 1, 1'b0, 1'b1, 'h8000, 0);
    tick(); push(0, "rd_grant", 1, 0, 0, 3);
    clear(0); s_rdv[0] = 'h1234;
    tick(); push(0, "rd_return", -1, 2, 1, 1);

    // device_busy for three cycles with cores 0 and 3 requesting
    s_rdv[0] = 0; s_rst[0] = 1;
    tick(); push(0, "busy_rst", -1, 2, 0, 1);
    s_rst[0] = 0; s_busy[0] = 1;
    req(0, 0, 1'b1, 1'b0, 'h0300, 'h3333); req(0, 3, 1'b0, 1'b1, 'h0303, 0);
    for (int k = 0; k < 3; k++) begin
      tick(); push(0, $sformatf("busy%0d", k), -1, 0, 0, 0);
    end
    s_busy[0] = 0;
    tick(); push(0, "busy_rel", 0, 0, 0, 0);
    tick(); push(0, "busy_next", 3, 1, 1, 0);

    // reset mid-stream after core 2 is granted
    clear(0); req(0, 2, 1'b1, 1'b0, 'h0402, 'h4444);
    tick(); push(0, "mid_g2", 2, 0, 1, 3);
    s_rst[0] = 1; req(0, 0, 1'b1, 1'b0, 'h0400, 'h4040);
    tick(); push(0, "mid_rst", -1, 3, 1, 2);
    s_rst[0] = 0;
    tick(); push(0, "mid_post", 0, 0, 0, 0);
    tick(); push(0, "mid_next", 2, 1, 1, 0);
    clear(0);
    tick(); push(0, "final", -1, 3, 1, 2);

    for (int k = 0; k < 5 && (q4.size() > 0 || q3.size() > 0); k++) @(negedge clk);
    #1;
    if (q4.size() > 0 || q3.size() > 0) begin
      n_total++;
      $display("FAIL drain: got %0d pending want 0", q4.size() + q3.size());
    end
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
